pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: load-use bubbles, branch flushes,
// memory-wait holds with timeout. Optional perf counters under HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ID_rs1,
   input  logic [REG_AW-1:0] ID_rs2,
   input  logic              ID_use_rs1,
   input  logic              ID_use_rs2,
   input  logic [REG_AW-1:0] ID_EX_rd,
   input  logic              ID_EX_MemRead,
   input  logic              EX_branch_taken,
   input  logic              EX_MEM_MemRead,
   input  logic              EX_MEM_MemWrite,
   input  logic              dmem_ready,
   output logic              dmem_req,
   output logic              pc_stall,
   output logic              IF_ID_stall,
   output logic              IF_ID_flush,
   output logic              ID_EX_stall,
   output logic              ID_EX_flush,
   output logic              EX_MEM_stall,
   output logic              MEM_WB_bubble,
   output logic              mem_timeout_err,
   output logic [CNT_W-1:0]  perf_stall,
   output logic [CNT_W-1:0]  perf_flush,
   output logic [CNT_W-1:0]  perf_lu
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {S_RUN, S_WAIT} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_cnt_nxt;
   logic          err_nxt;
   logic          mem_acc, lu, mstall, timeout_hit;

   assign mem_acc  = EX_MEM_MemRead | EX_MEM_MemWrite;
   assign dmem_req = mem_acc;

   assign lu = ID_EX_MemRead && (ID_EX_rd != '0) &&
               ((ID_use_rs1 && (ID_rs1 == ID_EX_rd)) || (ID_use_rs2 && (ID_rs2 == ID_EX_rd)));

   // wait_cnt is the number of stalled cycles already spent on this access, so the
   // access is released once it has been held for MEM_TIMEOUT cycles.
   assign timeout_hit = (state == S_WAIT) && (wait_cnt == CW'(MEM_TIMEOUT));
   assign mstall      = mem_acc && !dmem_ready && !timeout_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= S_RUN;
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         state           <= state_nxt;
         wait_cnt        <= wait_cnt_nxt;
         mem_timeout_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      err_nxt      = mem_timeout_err;
      case (state)
         S_RUN: begin
            if (mem_acc && !dmem_ready) begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = CW'(1);
            end
         end
         S_WAIT: begin
            if (!mem_acc || dmem_ready) begin
               state_nxt    = S_RUN;
               wait_cnt_nxt = '0;
            end else if (timeout_hit) begin
               state_nxt    = S_RUN;
               wait_cnt_nxt = '0;
               err_nxt      = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + CW'(1);
            end
         end
         default: begin
            state_nxt    = S_RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // A memory hold freezes the branch in EX, so its flush waits until the hold ends.
   always_comb begin
      pc_stall      = 1'b0;
      IF_ID_stall   = 1'b0;
      IF_ID_flush   = 1'b0;
      ID_EX_stall   = 1'b0;
      ID_EX_flush   = 1'b0;
      EX_MEM_stall  = 1'b0;
      MEM_WB_bubble = 1'b0;
      if (mstall) begin
         pc_stall      = 1'b1;
         IF_ID_stall   = 1'b1;
         ID_EX_stall   = 1'b1;
         EX_MEM_stall  = 1'b1;
         MEM_WB_bubble = 1'b1;
      end else if (EX_branch_taken) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (lu) begin
         pc_stall    = 1'b1;
         IF_ID_stall = 1'b1;
         ID_EX_flush = 1'b1;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic flush_ev, lu_ev;
   assign flush_ev = !mstall && EX_branch_taken;
   assign lu_ev    = !mstall && !EX_branch_taken && lu;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall <= '0;
         perf_flush <= '0;
         perf_lu    <= '0;
      end else begin
         if (mstall && !(&perf_stall))   perf_stall <= perf_stall + CNT_W'(1);
         if (flush_ev && !(&perf_flush)) perf_flush <= perf_flush + CNT_W'(1);
         if (lu_ev && !(&perf_lu))       perf_lu    <= perf_lu + CNT_W'(1);
      end
   end
`else
   assign perf_stall = '0;
   assign perf_flush = '0;
   assign perf_lu    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4); perf counters checked when
// HAZ_PERF_CNT_EN is defined, otherwise expected to read zero.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] ID_rs1, ID_rs2, ID_EX_rd;
   logic       ID_use_rs1, ID_use_rs2, ID_EX_MemRead, EX_branch_taken;
   logic       EX_MEM_MemRead, EX_MEM_MemWrite, dmem_ready;
   logic       dmem_req, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush;
   logic       EX_MEM_stall, MEM_WB_bubble, mem_timeout_err;
   logic [31:0] perf_stall, perf_flush, perf_lu;

   int checks = 0;
   int errors = 0;
   int m_stall = 0, m_flush = 0, m_lu = 0;

   // {dmem_req, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_bubble}
   localparam logic [7:0] O_NONE  = 8'b0000_0000;
   localparam logic [7:0] O_LU    = 8'b0110_0100;
   localparam logic [7:0] O_BR    = 8'b0001_0100;
   localparam logic [7:0] O_REQ   = 8'b1000_0000;
   localparam logic [7:0] O_MSTL  = 8'b1110_1011;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
      .ID_EX_rd(ID_EX_rd), .ID_EX_MemRead(ID_EX_MemRead), .EX_branch_taken(EX_branch_taken),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .dmem_ready(dmem_ready),
      .dmem_req(dmem_req), .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
      .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
      .MEM_WB_bubble(MEM_WB_bubble), .mem_timeout_err(mem_timeout_err),
      .perf_stall(perf_stall), .perf_flush(perf_flush), .perf_lu(perf_lu)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are already set by the caller (just after a falling edge); check the
   // combinational outputs, then advance the perf model across the next rising edge.
   task automatic step(input string tag, input logic [7:0] eo, input logic ee);
      #1;
      chk({tag, ".outs"}, {24'd0, dmem_req, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall,
                           ID_EX_flush, EX_MEM_stall, MEM_WB_bubble}, {24'd0, eo});
      chk({tag, ".err"}, {31'd0, mem_timeout_err}, {31'd0, ee});
`ifdef HAZ_PERF_CNT_EN
      chk({tag, ".pstall"}, perf_stall, m_stall);
      chk({tag, ".pflush"}, perf_flush, m_flush);
      chk({tag, ".plu"}, perf_lu, m_lu);
`else
      chk({tag, ".perf"}, perf_stall | perf_flush | perf_lu, 32'd0);
`endif
      if (rst) begin
         m_stall = 0; m_flush = 0; m_lu = 0;
      end else if (eo[1]) m_stall++;
      else if (eo[4]) m_flush++;
      else if (eo[6]) m_lu++;
      @(negedge clk);
   endtask

   task automatic set_lu(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                         input logic u1, input logic [4:0] r2, input logic u2);
      ID_EX_MemRead = mr; ID_EX_rd = rd; ID_rs1 = r1; ID_use_rs1 = u1; ID_rs2 = r2; ID_use_rs2 = u2;
   endtask

   task automatic set_mem(input logic rd, input logic wr, input logic rdy);
      EX_MEM_MemRead = rd; EX_MEM_MemWrite = wr; dmem_ready = rdy;
   endtask

   initial begin
      rst = 1'b1; EX_branch_taken = 1'b0;
      set_lu(0, 0, 0, 0, 0, 0);
      set_mem(0, 0, 0);
      @(negedge clk);
      step("reset", O_NONE, 1'b0);
      rst = 1'b0;
      step("idle", O_NONE, 1'b0);

      // load-use: lw x5 in EX, add x6,x5,x1 in ID
      set_lu(1, 5, 5, 1, 1, 1);   step("lu_rs1", O_LU, 1'b0);
      set_lu(0, 5, 6, 1, 5, 1);   step("lu_clear", O_NONE, 1'b0);
      set_lu(1, 0, 0, 1, 1, 1);   step("lu_rd0", O_NONE, 1'b0);
      set_lu(1, 5, 5, 0, 1, 1);   step("lu_nouse", O_NONE, 1'b0);
      set_lu(1, 7, 1, 1, 7, 0);   step("lu_rs2_nouse", O_NONE, 1'b0);
      set_lu(1, 7, 1, 1, 7, 1);   step("lu_rs2", O_LU, 1'b0);
      set_lu(0, 7, 1, 1, 7, 1);   step("lu_rs2_clr", O_NONE, 1'b0);

      // branch wins over load-use
      set_lu(1, 5, 5, 1, 0, 0); EX_branch_taken = 1'b1;
      step("br_lu", O_BR, 1'b0);
      set_lu(0, 0, 0, 0, 0, 0); step("br_only", O_BR, 1'b0);
      EX_branch_taken = 1'b0;   step("br_clr", O_NONE, 1'b0);

      // zero-latency access
      set_mem(1, 0, 1); step("zl_ld", O_REQ, 1'b0);
      set_mem(0, 1, 1); step("zl_st", O_REQ, 1'b0);

      // load waits 3 cycles; branch and load-use held off during the hold
      set_mem(1, 0, 0);           step("w3_c1", O_MSTL, 1'b0);
      EX_branch_taken = 1'b1;     step("w3_c2_br", O_MSTL, 1'b0);
      EX_branch_taken = 1'b0; set_lu(1, 5, 5, 1, 0, 0);
      step("w3_c3_lu", O_MSTL, 1'b0);
      set_lu(0, 0, 0, 0, 0, 0); set_mem(1, 0, 1);
      step("w3_rel", O_REQ, 1'b0);
      set_mem(0, 0, 0);           step("w3_after", O_NONE, 1'b0);

      // timeout: ready never comes, exactly 4 stalls then forced release
      set_mem(0, 1, 0);
      step("to_c1", O_MSTL, 1'b0);
      step("to_c2", O_MSTL, 1'b0);
      step("to_c3", O_MSTL, 1'b0);
      step("to_c4", O_MSTL, 1'b0);
      step("to_rel", O_REQ, 1'b0);
      set_mem(0, 0, 0);           step("to_err", O_NONE, 1'b1);
      step("to_sticky", O_NONE, 1'b1);

      // access withdrawn during WAIT: back to RUN, error unchanged
      set_mem(1, 0, 0);           step("drop_c1", O_MSTL, 1'b1);
      set_mem(0, 0, 0);           step("drop_gone", O_NONE, 1'b1);
      set_mem(1, 0, 1);           step("drop_zl", O_REQ, 1'b1);

      // reset in the middle of WAIT restarts the count and clears the error
      set_mem(1, 0, 0);
      step("rw_c1", O_MSTL, 1'b1);
      step("rw_c2", O_MSTL, 1'b1);
      rst = 1'b1;                 step("rw_rst", O_MSTL, 1'b1);
      rst = 1'b0;
      step("rw_n1", O_MSTL, 1'b0);
      step("rw_n2", O_MSTL, 1'b0);
      step("rw_n3", O_MSTL, 1'b0);
      step("rw_n4", O_MSTL, 1'b0);
      step("rw_rel", O_REQ, 1'b0);
      set_mem(0, 0, 0);           step("rw_err", O_NONE, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
